// File: rtl/lane_position_fsm.sv
// Lane position controller: steps a marker across NUM_POS lanes from left/right keys,
// with optional wrap, hold-to-repeat, and a 1-deep pending move while a draw is in flight.
module lane_position_fsm #(
  parameter  int NUM_POS       = 4,
  parameter  int START_POS     = 0,
  parameter  int WRAP          = 0,
  parameter  int REPEAT_CYCLES = 0,
  localparam int POS_W         = $clog2(NUM_POS)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             LeftIn,
  input  logic             RightIn,
  input  logic             DoneDrawing,
  output logic [POS_W-1:0] CurrPos,
  output logic [POS_W-1:0] PrevPos,
  output logic             DrawStart,
  output logic             Busy
);

  localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(NUM_POS - 1);
  localparam logic [POS_W-1:0] RESET_POS = POS_W'(START_POS);

  typedef enum logic {IDLE, WAIT_DRAW} state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] curr_q, curr_d;
  logic [POS_W-1:0] prev_q, prev_d;
  logic             draw_q, draw_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_right_q, pend_right_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             left_q, right_q;

  logic             lrise, rrise, both_rise, edge_req, held_one, tick;
  logic             req_valid, req_right;
  logic             exec_valid, exec_right;
  logic             target_ok, accept;
  logic [POS_W-1:0] target;

  always_comb begin
    lrise     = LeftIn & ~left_q;
    rrise     = RightIn & ~right_q;
    both_rise = lrise & rrise;
    edge_req  = lrise ^ rrise;
    held_one  = LeftIn ^ RightIn;
    tick      = (REPEAT_CYCLES > 0) && held_one && (rep_cnt_q == CNT_LAST);
    req_valid = edge_req | tick;
    req_right = edge_req ? rrise : RightIn;

    // A fresh request (including a simultaneous double rise) overrides anything pending.
    exec_valid = req_valid | (~both_rise & pend_valid_q);
    exec_right = req_valid ? req_right : pend_right_q;

    target    = curr_q;
    target_ok = 1'b1;
    if (exec_right) begin
      if (curr_q == LAST_POS) begin
        target    = '0;
        target_ok = (WRAP != 0);
      end else begin
        target = curr_q + POS_W'(1);
      end
    end else begin
      if (curr_q == '0) begin
        target    = LAST_POS;
        target_ok = (WRAP != 0);
      end else begin
        target = curr_q - POS_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    curr_d       = curr_q;
    prev_d       = prev_q;
    draw_d       = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_right_d = pend_right_q;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        pend_valid_d = 1'b0;
        if (exec_valid && target_ok) begin
          accept  = 1'b1;
          prev_d  = curr_q;
          curr_d  = target;
          draw_d  = 1'b1;
          state_d = WAIT_DRAW;
        end
      end
      WAIT_DRAW: begin
        if (both_rise) begin
          pend_valid_d = 1'b0;
        end else if (req_valid) begin
          pend_valid_d = 1'b1;
          pend_right_d = req_right;
        end
        if (DoneDrawing) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Restarting the count on a tick keeps the period fixed even if the tick is refused.
    if (!held_one || accept || tick) begin
      rep_cnt_d = '0;
    end else begin
      rep_cnt_d = rep_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= IDLE;
      curr_q       <= RESET_POS;
      prev_q       <= RESET_POS;
      draw_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_right_q <= 1'b0;
      rep_cnt_q    <= '0;
      left_q       <= 1'b1;
      right_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      curr_q       <= curr_d;
      prev_q       <= prev_d;
      draw_q       <= draw_d;
      pend_valid_q <= pend_valid_d;
      pend_right_q <= pend_right_d;
      rep_cnt_q    <= rep_cnt_d;
      left_q       <= LeftIn;
      right_q      <= RightIn;
    end
  end

  assign CurrPos   = curr_q;
  assign PrevPos   = prev_q;
  assign DrawStart = draw_q;
  assign Busy      = (state_q == WAIT_DRAW);

endmodule

// File: tb/tb_lane_position_fsm.sv
// Directed bench for lane_position_fsm: four configurations (plain, wrap, repeat, 5-lane wrap)
// exercised one scenario task at a time.
module tb_lane_position_fsm;

  logic       clk = 1'b0;
  logic [3:0] rst_n, lin, rin, done;
  logic [1:0] cur0, prv0, cur1, prv1;
  logic [2:0] cur2, prv2, cur3, prv3;
  logic [3:0] ds, busy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_position_fsm #(.NUM_POS(4), .START_POS(0), .WRAP(0), .REPEAT_CYCLES(0)) d0 (
    .Clock(clk), .Reset(rst_n[0]), .LeftIn(lin[0]), .RightIn(rin[0]), .DoneDrawing(done[0]),
    .CurrPos(cur0), .PrevPos(prv0), .DrawStart(ds[0]), .Busy(busy[0]));
  lane_position_fsm #(.NUM_POS(4), .START_POS(0), .WRAP(1), .REPEAT_CYCLES(0)) d1 (
    .Clock(clk), .Reset(rst_n[1]), .LeftIn(lin[1]), .RightIn(rin[1]), .DoneDrawing(done[1]),
    .CurrPos(cur1), .PrevPos(prv1), .DrawStart(ds[1]), .Busy(busy[1]));
  lane_position_fsm #(.NUM_POS(8), .START_POS(0), .WRAP(0), .REPEAT_CYCLES(8)) d2 (
    .Clock(clk), .Reset(rst_n[2]), .LeftIn(lin[2]), .RightIn(rin[2]), .DoneDrawing(done[2]),
    .CurrPos(cur2), .PrevPos(prv2), .DrawStart(ds[2]), .Busy(busy[2]));
  lane_position_fsm #(.NUM_POS(5), .START_POS(1), .WRAP(1), .REPEAT_CYCLES(0)) d3 (
    .Clock(clk), .Reset(rst_n[3]), .LeftIn(lin[3]), .RightIn(rin[3]), .DoneDrawing(done[3]),
    .CurrPos(cur3), .PrevPos(prv3), .DrawStart(ds[3]), .Busy(busy[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 4'b0000; lin = '0; rin = '0; done = '0;
    step(); step();
    checks++; if (cur0 !== 2'd0) begin errors++; $display("FAIL reset_cur0 got %0d want 0", cur0); end
    checks++; if (prv0 !== 2'd0) begin errors++; $display("FAIL reset_prv0 got %0d want 0", prv0); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy got %b want 0000", busy); end
    checks++; if (ds !== 4'b0000) begin errors++; $display("FAIL reset_ds got %b want 0000", ds); end
    checks++; if (cur3 !== 3'd1) begin errors++; $display("FAIL reset_cur3 got %0d want 1", cur3); end
    rst_n = 4'b1111;
    step();
    $display("reset: cur0=%0d prv0=%0d cur3=%0d busy=%b", cur0, prv0, cur3, busy);
  endtask

  task automatic test_single_move();
    int pulses = 0;
    rin[0] = 1'b1;
    step();
    pulses += ds[0];
    checks++; if (cur0 !== 2'd1) begin errors++; $display("FAIL move_cur got %0d want 1", cur0); end
    checks++; if (prv0 !== 2'd0) begin errors++; $display("FAIL move_prv got %0d want 0", prv0); end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL move_busy got %b want 1", busy[0]); end
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += ds[0];
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL move_busy_hold%0d got %b want 1", i, busy[0]); end
    end
    done[0] = 1'b1;
    step();
    pulses += ds[0];
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL move_busy_fall got %b want 0", busy[0]); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL move_pulses got %0d want 1", pulses); end
    checks++; if (cur0 !== 2'd1) begin errors++; $display("FAIL move_cur_final got %0d want 1", cur0); end
    done[0] = 1'b0; rin[0] = 1'b0;
    step();
    $display("single_move: cur0=%0d prv0=%0d pulses=%0d", cur0, prv0, pulses);
  endtask

  task automatic test_back_to_back();
    rin[0] = 1'b1; step();
    checks++; if (cur0 !== 2'd2 || prv0 !== 2'd1 || ds[0] !== 1'b1) begin errors++;
      $display("FAIL b2b_first got cur=%0d prv=%0d ds=%b want 2 1 1", cur0, prv0, ds[0]); end
    rin[0] = 1'b0; step();
    rin[0] = 1'b1; step();
    checks++; if (cur0 !== 2'd2 || ds[0] !== 1'b0) begin errors++;
      $display("FAIL b2b_stall got cur=%0d ds=%b want 2 0", cur0, ds[0]); end
    rin[0] = 1'b0; done[0] = 1'b1; step();
    checks++; if (busy[0] !== 1'b0 || cur0 !== 2'd2) begin errors++;
      $display("FAIL b2b_done got busy=%b cur=%0d want 0 2", busy[0], cur0); end
    done[0] = 1'b0; step();
    checks++; if (cur0 !== 2'd3 || prv0 !== 2'd2 || ds[0] !== 1'b1) begin errors++;
      $display("FAIL b2b_pending got cur=%0d prv=%0d ds=%b want 3 2 1", cur0, prv0, ds[0]); end
    done[0] = 1'b1; step(); done[0] = 1'b0;
    lin[0] = 1'b1; rin[0] = 1'b1; step();
    checks++; if (cur0 !== 2'd3 || ds[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++;
      $display("FAIL b2b_both got cur=%0d ds=%b busy=%b want 3 0 0", cur0, ds[0], busy[0]); end
    lin[0] = 1'b0; rin[0] = 1'b0; step();
    rin[0] = 1'b1; step();
    checks++; if (cur0 !== 2'd3 || ds[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++;
      $display("FAIL nowrap_right got cur=%0d ds=%b busy=%b want 3 0 0", cur0, ds[0], busy[0]); end
    rin[0] = 1'b0; step();
    $display("back_to_back: cur0=%0d prv0=%0d", cur0, prv0);
  endtask

  task automatic test_pending_rules();
    lin[0] = 1'b1; step();
    checks++; if (cur0 !== 2'd2) begin errors++; $display("FAIL pend_left got cur=%0d want 2", cur0); end
    lin[0] = 1'b0; step();
    rin[0] = 1'b1; step();
    rin[0] = 1'b0; step();
    lin[0] = 1'b1; rin[0] = 1'b1; step();
    lin[0] = 1'b0; rin[0] = 1'b0; done[0] = 1'b1; step();
    done[0] = 1'b0; step();
    checks++; if (cur0 !== 2'd2 || ds[0] !== 1'b0) begin errors++;
      $display("FAIL pend_clear got cur=%0d ds=%b want 2 0", cur0, ds[0]); end
    lin[0] = 1'b1; step();
    checks++; if (cur0 !== 2'd1 || prv0 !== 2'd2) begin errors++;
      $display("FAIL pend_left2 got cur=%0d prv=%0d want 1 2", cur0, prv0); end
    lin[0] = 1'b0; step();
    rin[0] = 1'b1; step();
    rin[0] = 1'b0; step();
    lin[0] = 1'b1; step();
    lin[0] = 1'b0; done[0] = 1'b1; step();
    done[0] = 1'b0; step();
    checks++; if (cur0 !== 2'd0 || prv0 !== 2'd1 || ds[0] !== 1'b1) begin errors++;
      $display("FAIL pend_overwrite got cur=%0d prv=%0d ds=%b want 0 1 1", cur0, prv0, ds[0]); end
    done[0] = 1'b1; step(); done[0] = 1'b0;
    $display("pending_rules: cur0=%0d prv0=%0d", cur0, prv0);
  endtask

  task automatic test_wrap();
    lin[1] = 1'b1; step();
    checks++; if (cur1 !== 2'd3 || prv1 !== 2'd0 || ds[1] !== 1'b1) begin errors++;
      $display("FAIL wrap_left got cur=%0d prv=%0d ds=%b want 3 0 1", cur1, prv1, ds[1]); end
    lin[1] = 1'b0; done[1] = 1'b1; step(); done[1] = 1'b0;
    rin[1] = 1'b1; step();
    checks++; if (cur1 !== 2'd0 || prv1 !== 2'd3 || ds[1] !== 1'b1) begin errors++;
      $display("FAIL wrap_right got cur=%0d prv=%0d ds=%b want 0 3 1", cur1, prv1, ds[1]); end
    rin[1] = 1'b0; done[1] = 1'b1; step(); done[1] = 1'b0;
    $display("wrap: cur1=%0d prv1=%0d", cur1, prv1);
  endtask

  task automatic test_repeat();
    int moves = 0;
    done[2] = 1'b1; rin[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      moves += ds[2];
      checks++; if (ds[2] !== ((i % 8) == 0)) begin errors++;
        $display("FAIL repeat_ds cycle %0d got %b want %b", i, ds[2], ((i % 8) == 0)); end
    end
    checks++; if (cur2 !== 3'd3 || moves !== 3) begin errors++;
      $display("FAIL repeat_final got cur=%0d moves=%0d want 3 3", cur2, moves); end
    rin[2] = 1'b0; step();
    $display("repeat: cur2=%0d moves=%0d", cur2, moves);
  endtask

  task automatic test_reset_pending();
    lin[3] = 1'b1; step();
    checks++; if (cur3 !== 3'd0 || prv3 !== 3'd1) begin errors++;
      $display("FAIL n5_left got cur=%0d prv=%0d want 0 1", cur3, prv3); end
    lin[3] = 1'b0; done[3] = 1'b1; step(); done[3] = 1'b0;
    lin[3] = 1'b1; step();
    checks++; if (cur3 !== 3'd4 || prv3 !== 3'd0) begin errors++;
      $display("FAIL n5_wrap got cur=%0d prv=%0d want 4 0", cur3, prv3); end
    lin[3] = 1'b0; step();
    rin[3] = 1'b1; step();
    rst_n[3] = 1'b0; step();
    checks++; if (cur3 !== 3'd1 || prv3 !== 3'd1 || busy[3] !== 1'b0 || ds[3] !== 1'b0) begin errors++;
      $display("FAIL n5_reset got cur=%0d prv=%0d busy=%b ds=%b want 1 1 0 0", cur3, prv3, busy[3], ds[3]); end
    rst_n[3] = 1'b1; step();
    checks++; if (cur3 !== 3'd1 || ds[3] !== 1'b0 || busy[3] !== 1'b0) begin errors++;
      $display("FAIL n5_held got cur=%0d ds=%b busy=%b want 1 0 0", cur3, ds[3], busy[3]); end
    rin[3] = 1'b0; step(); step();
    checks++; if (cur3 !== 3'd1 || busy[3] !== 1'b0) begin errors++;
      $display("FAIL n5_quiet got cur=%0d busy=%b want 1 0", cur3, busy[3]); end
    $display("reset_pending: cur3=%0d busy3=%b", cur3, busy[3]);
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_back_to_back();
    test_pending_rules();
    test_wrap();
    test_repeat();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
